sipo_deframer: RTL
==================

# sipo_deframer

Serial-to-parallel deframer for the serial link driven by the PISO transmitter. It accepts one bit per handshake on the `clk_s` domain and reassembles WIDTH-bit words LSB-first. Completed words are buffered in a small show-ahead output FIFO and presented on a parallel valid/ready port to the downstream consumer. It is the receive-side counterpart of the PISO stage and sits directly downstream of it.

## Interface

**Parameters**
- `WIDTH`, default 8: bits per word; must be ≥ 2.
- `OUT_DEPTH`, default 4: output FIFO entries; must be a power of 2, ≥ 2.

**Ports**
- `clk_s`  in  1: serial-domain clock; all logic on the rising edge.
- `rst_i`  in  1: reset, asynchronous assert, active-low (0 = reset).
- `d_i`  in  1: serial data bit.
- `valid_i`  in  1: `d_i` carries a bit this cycle.
- `ready_o`  out  1: deframer can accept a bit this cycle.
- `flush_i`  in  1: synchronous discard of the partially assembled word.
- `d_o`  out  WIDTH: head-of-FIFO word; forced to 0 when `valid_o` = 0.
- `valid_o`  out  1: `d_o` holds a word.
- `ready_i`  in  1: consumer takes the word this cycle.
- `count_o`  out  $clog2(OUT_DEPTH)+1: number of FIFO entries.

## Operation

- **Bit accept:** `valid_i` && `ready_o` && !`flush_i`. Bit k of a word (k = 0..WIDTH-1) is the k-th accepted bit, so the word is LSB-first.
- **Assembly:** `bit_cnt` runs 0..WIDTH-1.
  - Shift register is right-shifted, with the new bit entering at the MSB.
  - On acceptance of bit WIDTH-1, the word {`d_i`, `shreg[WIDTH-1:1]`} is pushed into the FIFO at that same edge, and `bit_cnt` returns to 0.
- **States:**
  - **S_IDLE** (`bit_cnt` = 0): accept → S_SHIFT.
  - **S_SHIFT** (0 < `bit_cnt` < WIDTH-1): accept increments `bit_cnt`; reaching WIDTH-1 → S_LAST.
  - **S_LAST** (`bit_cnt` = WIDTH-1):
    - If FIFO not full: accept pushes the word → S_IDLE.
    - If FIFO full: stay in S_LAST.
  - `flush_i` = 1 in any state → S_IDLE with `bit_cnt` and `shreg` cleared; FIFO is untouched.
- **`ready_o`:** `!(state == S_LAST && count == OUT_DEPTH)`.
  - Depends on registered state only; no combinational path from `ready_i`.
  - A pop in the same cycle does not raise `ready_o`.
- **Pop:** `valid_o` && `ready_i`. Advance the read pointer and decrement the count.
  - Push and pop in the same cycle leave `count_o` unchanged.
  - Full-plus-push cannot occur.
- **`valid_o`:** (count ≠ 0). `d_o` = mem[rd_ptr] when `valid_o` = 1, else 0.
- **Pointers:** $clog2(OUT_DEPTH) bits each, wrapping modulo OUT_DEPTH. Count saturates by construction at OUT_DEPTH.
- **Priority:** `flush_i` over bit accept. Bits offered while `ready_o` = 0 are not consumed; the sender holds them.

## Timing

- **Reset** (`rst_i` = 0, asynchronous), all values immediate:
  - state = S_IDLE, `bit_cnt` = 0, `shreg` = 0, FIFO pointers and count = 0.
  - Outputs: `ready_o` = 1, `valid_o` = 0, `d_o` = 0, `count_o` = 0.
- **Reset mid-word:** partial bits are lost; FIFO contents are discarded. Release is synchronous to the next `clk_s` edge.
- **Latency:** last bit accepted at edge N → `valid_o` = 1 and `d_o` = word during cycle N+1 (from an empty FIFO).
- **Throughput:** one bit per cycle, sustained with `valid_i` = `ready_i` = 1; no bubble between words.
- **Backpressure:** with a full FIFO, `ready_o` falls during S_LAST. It rises the cycle after the first pop.
- **Gaps:** `valid_i` gaps of any length between bits preserve `bit_cnt` and `shreg`.

## Test plan

- **Single word:** after reset, send bits 1,0,1,0,0,1,0,1 back-to-back with `ready_i` = 1 → `valid_o` = 1 for exactly one cycle, one cycle after the 8th bit, with `d_o` = 0xA5; `count_o` returns to 0.
- **Backpressure:** hold `ready_i` = 0 and stream 5 words 0x01..0x05.
  - `count_o` reaches 4.
  - `ready_o` = 0 while the 8th bit of 0x05 is pending.
  - Then raise `ready_i` → `d_o` yields 0x01, 0x02, 0x03, 0x04, 0x05 in order, and `ready_o` rises the cycle after the first pop.
- **Gapped input:** send 0x3C with `valid_i` toggling 1,0,1,0… → `d_o` = 0x3C; `count_o` increments only after the final accepted bit.
- **Flush mid-word:** send 3 bits, pulse `flush_i` together with a 4th valid bit, then send 0xF0 → only 0xF0 appears; the 4th bit is dropped.
- **Simultaneous push/pop:** with `count_o` = 1 and `ready_i` = 1, complete a new word → `count_o` stays 1; the old word pops and the new word is the next head.
- **Reset mid-operation:** assert `rst_i` = 0 asynchronously after 5 bits with 2 words buffered → `valid_o` = 0, `d_o` = 0, `count_o` = 0, `ready_o` = 1 immediately; the next 8 bits form a clean word.

Source files
------------

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: LSB-first bits on clk_s become WIDTH-bit words in a show-ahead FIFO.
// Latency: last bit at edge N -> word on d_o in cycle N+1. ready_o drops only in S_LAST with a full FIFO.
module sipo_deframer #(
    parameter int WIDTH     = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk_s,
    input  logic                         rst_i,
    input  logic                         d_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             d_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(OUT_DEPTH):0]   count_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(OUT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LAST  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [WIDTH-1:0]  shreg_q;

    logic [WIDTH-1:0]  mem_q [OUT_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;

    logic              accept;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  word_d;
    logic [CW-1:0]     bit_cnt_d;

    // Full-FIFO stall looks only at registered state, so a same-cycle pop cannot reopen it.
    assign ready_o   = !(state_q == S_LAST && count_q == FULL_CNT);
    assign accept    = valid_i && ready_o && !flush_i;
    assign push      = accept && (state_q == S_LAST);
    assign pop       = valid_o && ready_i;
    assign word_d    = {d_i, shreg_q[WIDTH-1:1]};
    assign bit_cnt_d = bit_cnt_q + CW'(1);

    always_ff @(posedge clk_s or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else if (flush_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else if (accept) begin
            case (state_q)
                S_IDLE, S_SHIFT: begin
                    shreg_q   <= word_d;
                    bit_cnt_q <= bit_cnt_d;
                    state_q   <= (bit_cnt_d == LAST_CNT) ? S_LAST : S_SHIFT;
                end
                default: begin
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_s or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable through the pointers.
    always_ff @(posedge clk_s) begin
        if (push) mem_q[wr_ptr_q] <= word_d;
    end

    assign valid_o = (count_q != '0);
    assign d_o     = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule
